// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with registered status flags
// Ports: clk, rst (async active-high); wr_en/wr_data push; rd_en pop;
//   rd_data head word; full/empty/almost_full/almost_empty/count status;
//   overflow/underflow one-cycle pulses for rejected write/read.
module sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic wr_ok, rd_ok;
  // a write into a full FIFO is still accepted when a pop frees the slot on the same edge
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];
  always_comb count_nxt = count + CW'(wr_ok) - CW'(rd_ok);
  always_ff @(posedge clk)
    if (wr_ok && !rst) mem[wr_ptr] <= wr_data;
  // flags are derived from the next count so they change on the same edge as count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
      count        <= count_nxt;
      full         <= count_nxt == CW'(DEPTH);
      empty        <= count_nxt == '0;
      almost_full  <= count_nxt >= CW'(AFULL_LEVEL);
      almost_empty <= count_nxt <= CW'(AEMPTY_LEVEL);
      overflow     <= wr_en & ~wr_ok;
      underflow    <= rd_en & ~rd_ok;
    end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, pointer width; depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AFULL_LEVEL, default DEPTH-2; almost_full asserts when count >= AFULL_LEVEL.
REQ-004 The block SHALL have parameter AEMPTY_LEVEL, default 2; almost_empty asserts when count <= AEMPTY_LEVEL.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  write word.
REQ-009 rd_en  input  1  read (pop) request.
REQ-010 rd_data  output  DATA_WIDTH  head-of-queue word, first-word-fall-through.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 almost_full  output  1  count >= AFULL_LEVEL.
REQ-014 almost_empty  output  1  count <= AEMPTY_LEVEL.
REQ-015 count  output  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
REQ-016 overflow  output  1  one-cycle pulse, rejected write in previous cycle.
REQ-017 underflow  output  1  one-cycle pulse, rejected read in previous cycle.

Function
REQ-018 Storage SHALL be a DEPTH x DATA_WIDTH array with one synchronous write port (wr_ptr) and one asynchronous read port (rd_ptr).
REQ-019 A write SHALL be accepted when wr_en=1 and (full=0 or rd_en=1); accepted write stores wr_data at wr_ptr, wr_ptr increments mod DEPTH.
REQ-020 A read SHALL be accepted when rd_en=1 and empty=0; accepted read increments rd_ptr mod DEPTH.
REQ-021 rd_data SHALL equal mem[rd_ptr] combinationally; value is valid whenever empty=0, don't-care when empty=1.
REQ-022 Word written into an empty FIFO SHALL appear on rd_data and empty SHALL deassert one cycle after the write edge (write-to-read latency 1 cycle).
REQ-023 count SHALL update per edge: +1 write only, -1 read only, unchanged for both or neither accepted.
REQ-024 full, empty, almost_full, almost_empty SHALL be registered, updated on the same edge as count, never combinational from inputs.
REQ-025 Simultaneous rd_en and wr_en when full SHALL accept both; count stays DEPTH, full stays 1.
REQ-026 Simultaneous rd_en and wr_en when empty SHALL accept only the write; underflow pulses; count becomes 1.
REQ-027 wr_en=1 rejected (full=1, rd_en=0) SHALL leave memory, pointers, count unchanged and assert overflow for exactly the next cycle.
REQ-028 rd_en=1 rejected (empty=1) SHALL leave state unchanged and assert underflow for exactly the next cycle.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 without disturbing count or flags.
REQ-030 Parameter legality: 1 <= AEMPTY_LEVEL < AFULL_LEVEL <= DEPTH-1; other values unsupported.

Reset
REQ-031 rst=1 SHALL immediately, without clock, set wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-032 Memory contents SHALL NOT be reset; data in flight at reset is discarded.
REQ-033 Reset asserted mid-operation SHALL override any concurrent wr_en/rd_en; first accepted write after release lands at address 0.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, DEPTH=4, AFULL_LEVEL=3, AEMPTY_LEVEL=1)
REQ-034 Reset then idle -> count=0, empty=1, almost_empty=1, full=0, overflow=0, underflow=0.
REQ-035 Write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; empty low after first edge; almost_empty low at count 2; almost_full at count 3; full at count 4; rd_data=0x11 throughout.
REQ-036 Full, write 0x55 without read -> overflow pulses 1 cycle, count=4; then 4 reads -> rd_data 0x11,0x22,0x33,0x44 in order, empty=1 after last.
REQ-037 Full, rd_en=1 and wr_en=1 with 0x55 -> count stays 4; subsequent reads return 0x22,0x33,0x44,0x55 (wrap exercised).
REQ-038 Empty, rd_en=1 and wr_en=1 with 0xA5 -> underflow pulses, count=1, rd_data=0xA5 next cycle.
REQ-039 Write 3 words, assert rst asynchronously between edges -> count=0, empty=1 before next edge; next write 0x77 read back as 0x77.
